// File: rtl/filter_accel_prod_acc_if.sv
// Product-in / pixel-out stream bundle for the filter accumulate stage.
// master = upstream multiplier + downstream consumer side; slave = the accumulator.
interface filter_accel_prod_acc_if #(
    parameter int PROD_WIDTH = 18,
    parameter int OUT_WIDTH  = 11
);
    // Both streams: a beat transfers on a rising edge where tvalid & tready are both 1;
    // a source holds tdata/tlast stable while tvalid=1 and tready=0.
    logic [PROD_WIDTH-1:0] prod_tdata;
    logic                  prod_tvalid;
    logic                  prod_tlast;
    logic                  prod_tready;
    logic [OUT_WIDTH-1:0]  pix_tdata;
    logic                  pix_tvalid;
    logic                  pix_tready;

    modport master (
        output prod_tdata, prod_tvalid, prod_tlast, pix_tready,
        input  prod_tready, pix_tdata, pix_tvalid
    );

    modport slave (
        input  prod_tdata, prod_tvalid, prod_tlast, pix_tready,
        output prod_tready, pix_tdata, pix_tvalid
    );
endinterface

// File: rtl/filter_accel_prod_acc.sv
// Sums TAPS unsigned products per pixel, rounds, shifts to pixel scale, saturates,
// and holds the result in a registered valid/ready output.
module filter_accel_prod_acc #(
    parameter int PROD_WIDTH = 18,
    parameter int TAPS       = 25,
    parameter int ACC_WIDTH  = 23,
    parameter int SHIFT      = 7,
    parameter int OUT_WIDTH  = 11
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    clr,
    filter_accel_prod_acc_if.slave  bus,
    output logic                    err_align,
    output logic [1:0]              dbg_state
);
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0]        LAST_TAP = CW'(TAPS - 1);
    localparam logic [ACC_WIDTH:0]   RND      = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic [ACC_WIDTH:0]   MAXV     = (ACC_WIDTH + 1)'((1 << OUT_WIDTH) - 1);

    typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_ACCUM = 2'd1, PH_FINAL = 2'd2} phase_e;

    logic [CW-1:0]        cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 is_final;
    logic                 hs;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH:0]   shifted;
    logic [OUT_WIDTH-1:0] sat;
    phase_e               phase;

    assign is_final        = (cnt == LAST_TAP);
    // Only the final tap needs room in the output register; earlier taps never stall.
    assign bus.prod_tready = !(is_final && bus.pix_tvalid && !bus.pix_tready);
    assign hs              = bus.prod_tvalid && bus.prod_tready;

    always_comb begin
        sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, bus.prod_tdata};
        shifted = (sum + RND) >> SHIFT;
        sat     = (shifted > MAXV) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
    end

    always_comb begin
        phase = PH_ACCUM;
        if (cnt == '0)
            phase = PH_IDLE;
        else if (is_final)
            phase = PH_FINAL;
    end
    assign dbg_state = phase;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt           <= '0;
            acc           <= '0;
            bus.pix_tdata <= '0;
            bus.pix_tvalid <= 1'b0;
            err_align     <= 1'b0;
        end else if (clr) begin
            // A product presented alongside clr is dropped.
            cnt            <= '0;
            acc            <= '0;
            bus.pix_tvalid <= 1'b0;
            err_align      <= 1'b0;
        end else begin
            if (bus.pix_tvalid && bus.pix_tready)
                bus.pix_tvalid <= 1'b0;
            if (hs) begin
                if (bus.prod_tlast != is_final)
                    err_align <= 1'b1;
                if (is_final) begin
                    bus.pix_tdata  <= sat;
                    bus.pix_tvalid <= 1'b1;
                    cnt            <= '0;
                end else begin
                    acc <= ((cnt == '0) ? '0 : acc)
                         + {{(ACC_WIDTH - PROD_WIDTH){1'b0}}, bus.prod_tdata};
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
